pc_sequencer: RTL and testbench

Owns the program counter for the pipelined RISC-V core and sequences every PC update: sequential fetch, stall hold, EX-stage branch/jump redirect, and trap vectoring. It holds the PC register internally and drives instruction memory with fetch_pc. It generates flush pulses for the front-end pipeline registers and captures the exception PC. It sits between the hazard unit, the EX branch logic, the decode trap logic and the instruction memory.

---
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner for the pipelined RISC-V core.
// Sequences fetch, stall hold, EX redirects, trap vectoring, flush and halt.
`default_nettype none

module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        trap,
   input  logic [31:0] trap_pc,
   input  logic        halt_req,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic        flush,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [2:0] flush_cnt;
   logic       shadow;
   logic       accept;
   logic       take_trap;
   logic       take_br;
   logic       misaligned;
   logic       redirect;
   logic       go_halt;

   // Control inputs seen during the shadow window belong to squashed instructions.
   assign shadow     = (flush_cnt != 3'd0);
   assign accept     = (state == ST_RUN) && !shadow;
   assign take_trap  = accept && trap;
   assign take_br    = accept && !trap && br_taken;
   assign misaligned = (br_target[1:0] != 2'b00);
   assign redirect   = take_trap || take_br;
   assign go_halt    = accept && !trap && !br_taken && halt_req;
   assign flush      = redirect || shadow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_BOOT;
         fetch_pc    <= RESET_VECTOR;
         fetch_valid <= 1'b0;
         halted      <= 1'b0;
         epc         <= 32'h0;
         cause       <= 2'd0;
         flush_cnt   <= 3'd0;
      end else begin
         if (redirect) begin
            flush_cnt <= FLUSH_LOAD;
         end else if (shadow) begin
            flush_cnt <= flush_cnt - 3'd1;
         end

         case (state)
            ST_BOOT: begin
               state       <= ST_RUN;
               fetch_valid <= 1'b1;
            end
            ST_RUN: begin
               // Redirects take precedence over stall/imem_ready; any pending fetch is dropped.
               if (take_trap) begin
                  fetch_pc <= TRAP_VECTOR;
                  epc      <= trap_pc;
                  cause    <= 2'd1;
               end else if (take_br && !misaligned) begin
                  fetch_pc <= br_target;
               end else if (take_br) begin
                  fetch_pc <= TRAP_VECTOR;
                  epc      <= br_target;
                  cause    <= 2'd2;
               end else if (go_halt) begin
                  state       <= ST_HALT;
                  fetch_valid <= 1'b0;
                  halted      <= 1'b1;
               end else if (!stall && imem_ready) begin
                  fetch_pc <= fetch_pc + 32'd4;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state       <= ST_BOOT;
               fetch_valid <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
`default_nettype none

module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        imem_ready;
   logic        br_taken;
   logic [31:0] br_target;
   logic        trap;
   logic [31:0] trap_pc;
   logic        halt_req;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        flush;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic        halted;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .imem_ready  (imem_ready),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .trap        (trap),
      .trap_pc     (trap_pc),
      .halt_req    (halt_req),
      .fetch_pc    (fetch_pc),
      .fetch_valid (fetch_valid),
      .flush       (flush),
      .epc         (epc),
      .cause       (cause),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      br_taken  = 1'b0;
      br_target = 32'h0;
      trap      = 1'b0;
      trap_pc   = 32'h0;
      halt_req  = 1'b0;
      stall     = 1'b0;
      imem_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      clear_ctl();
      tick();
      tick();
      check_val("rst_pc", fetch_pc, 32'h0);
      check_val("rst_valid", {31'b0, fetch_valid}, 32'h0);
      check_val("rst_flush", {31'b0, flush}, 32'h0);
      check_val("rst_epc", epc, 32'h0);
      check_val("rst_cause", {30'b0, cause}, 32'h0);
      check_val("rst_halted", {31'b0, halted}, 32'h0);

      // 1: boot then sequential fetch
      rst = 1'b1;
      #1;
      check_val("boot_valid", {31'b0, fetch_valid}, 32'h0);
      tick();
      check_val("run_valid", {31'b0, fetch_valid}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         check_val("seq_pc", fetch_pc, 32'(i * 4));
         if (i < 4) tick();
      end

      // 2: stall 3 cycles then imem not ready 2 cycles at 0x10
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            stall = 1'b0;
            imem_ready = 1'b0;
         end
         tick();
         check_val("stall_hold", fetch_pc, 32'h10);
      end
      imem_ready = 1'b1;
      tick();
      check_val("stall_release", fetch_pc, 32'h14);
      tick(); tick(); tick();
      check_val("pre_br_pc", fetch_pc, 32'h20);

      // 3: branch with stall, second branch lands in shadow
      br_taken = 1'b1; br_target = 32'h80; stall = 1'b1;
      #1;
      check_val("br_flush0", {31'b0, flush}, 32'h1);
      tick();
      check_val("br_pc", fetch_pc, 32'h80);
      br_target = 32'h40; stall = 1'b0;
      #1;
      check_val("br_flush1", {31'b0, flush}, 32'h1);
      tick();
      clear_ctl();
      #1;
      check_val("br_shadow_pc", fetch_pc, 32'h84);
      check_val("br_flush2", {31'b0, flush}, 32'h0);

      // 4: trap beats branch
      trap = 1'b1; trap_pc = 32'h44; br_taken = 1'b1; br_target = 32'h90;
      #1;
      check_val("trap_flush0", {31'b0, flush}, 32'h1);
      tick();
      clear_ctl();
      #1;
      check_val("trap_pc", fetch_pc, 32'h100);
      check_val("trap_epc", epc, 32'h44);
      check_val("trap_cause", {30'b0, cause}, 32'h1);
      check_val("trap_flush1", {31'b0, flush}, 32'h1);
      // trap in the shadow must be ignored
      trap = 1'b1; trap_pc = 32'h500;
      tick();
      clear_ctl();
      #1;
      check_val("trap_shadow_pc", fetch_pc, 32'h104);
      check_val("trap_shadow_epc", epc, 32'h44);
      check_val("trap_flush2", {31'b0, flush}, 32'h0);

      // 5: misaligned target, then wrap at top of address space
      br_taken = 1'b1; br_target = 32'h82;
      tick();
      clear_ctl();
      #1;
      check_val("mis_pc", fetch_pc, 32'h100);
      check_val("mis_epc", epc, 32'h82);
      check_val("mis_cause", {30'b0, cause}, 32'h2);
      tick();
      check_val("mis_next", fetch_pc, 32'h104);
      br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
      tick();
      clear_ctl();
      #1;
      check_val("wrap_top", fetch_pc, 32'hFFFF_FFFC);
      check_val("wrap_cause_kept", {30'b0, cause}, 32'h2);
      tick();
      check_val("wrap_zero", fetch_pc, 32'h0);
      tick();
      check_val("wrap_four", fetch_pc, 32'h4);

      // 6: halt with stall, inputs ignored, async reset
      halt_req = 1'b1; stall = 1'b1;
      tick();
      clear_ctl();
      #1;
      check_val("halt_halted", {31'b0, halted}, 32'h1);
      check_val("halt_valid", {31'b0, fetch_valid}, 32'h0);
      check_val("halt_pc", fetch_pc, 32'h4);
      br_taken = 1'b1; br_target = 32'h200; trap = 1'b1; trap_pc = 32'h300;
      #1;
      check_val("halt_noflush", {31'b0, flush}, 32'h0);
      tick();
      tick();
      clear_ctl();
      #1;
      check_val("halt_frozen", fetch_pc, 32'h4);
      check_val("halt_epc_kept", epc, 32'h82);
      #1;
      rst = 1'b0;
      #1;
      check_val("arst_pc", fetch_pc, 32'h0);
      check_val("arst_halted", {31'b0, halted}, 32'h0);
      check_val("arst_valid", {31'b0, fetch_valid}, 32'h0);
      check_val("arst_epc", epc, 32'h0);
      check_val("arst_cause", {30'b0, cause}, 32'h0);
      check_val("arst_flush", {31'b0, flush}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
